alu_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single 4-bit combinational ALU among NREQ requesters.
- Latches the winner's opcode and operands, drives the ALU for one cycle, and captures the result.
- Returns the result with the requester ID over a valid/ready response channel.
- Sits between the requesting units (sequencers, test drivers) and the ALU instance.

---
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing one 4-bit combinational ALU
// among NREQ requesters. The winner's opcode and operands are latched onto the
// ALU port for one cycle and the result is returned over a valid/ready channel
// together with the requester index.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   req[NREQ]           request bit per requester
//   req_oc/req_a/req_b  packed per-requester opcode (3b) / operand A, B (4b)
//   gnt[NREQ]           one-hot, single-cycle grant; operands consumed
//   alu_oc/alu_a/alu_b  registered drive to the shared ALU
//   alu_f               ALU result, combinational from alu_*
//   rsp_valid/rsp_ready response handshake
//   rsp_id/rsp_f/rsp_err requester index, result, divide-by-zero flag
//   busy                high whenever the sequencer is not idle
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [3*NREQ-1:0]   req_oc,
  input  logic [4*NREQ-1:0]   req_a,
  input  logic [4*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     gnt,
  output logic [2:0]          alu_oc,
  output logic [3:0]          alu_a,
  output logic [3:0]          alu_b,
  input  logic [3:0]          alu_f,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [3:0]          rsp_f,
  output logic                rsp_err,
  output logic                busy
);

  localparam logic [2:0] OC_DIV = 3'b011;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [3:0]     f;
    logic           err;
  } rsp_t;

  state_t state, state_nxt;
  rsp_t   rsp_q;

  logic [NREQ-1:0][2:0] oc_v;
  logic [NREQ-1:0][3:0] a_v;
  logic [NREQ-1:0][3:0] b_v;

  logic [IDW-1:0] last;
  logic [IDW-1:0] win;
  logic           win_vld;
  logic           div0;

  // Flat port vectors reinterpreted as per-requester slices.
  assign oc_v = req_oc;
  assign a_v  = req_a;
  assign b_v  = req_b;

  // Round-robin search: first set bit starting just after the last winner.
  always_comb begin
    logic [IDW-1:0] idx;
    idx     = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last) + k) % NREQ);
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  assign div0 = (alu_oc == OC_DIV) && (alu_b == 4'h0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt       <= '0;
      alu_oc    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      busy      <= 1'b0;
      last      <= IDW'(NREQ - 1);
    end else begin
      gnt  <= '0;
      busy <= (state_nxt != IDLE);
      if (state == IDLE && win_vld) begin
        gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << win;
        alu_oc <= oc_v[win];
        alu_a  <= a_v[win];
        alu_b  <= b_v[win];
        last   <= win;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_q.id  <= last;
        // Divide-by-zero is reported here; whatever the ALU produced is dropped.
        rsp_q.f   <= div0 ? 4'hF : alu_f;
        rsp_q.err <= div0;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

  assign rsp_id  = rsp_q.id;
  assign rsp_f   = rsp_q.f;
  assign rsp_err = rsp_q.err;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] req_oc;
  logic [4*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]   gnt;
  logic [2:0]        alu_oc;
  logic [3:0]        alu_a, alu_b, alu_f;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_f;
  logic              rsp_err;
  logic              busy;

  int checks = 0, passes = 0, cyc = 0;
  int m_last;           // model round-robin pointer
  int g_cyc;            // cycle at which the most recent grant was seen
  logic [NREQ-1:0] g_seen;

  always #5 clk = ~clk;

  // Stand-in ALU; divide by zero yields 0 so the arbiter's override is visible.
  function automatic logic [3:0] alu_model(input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
    case (oc)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return (b == 0) ? 4'h0 : a / b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return a * b;
      default: return ~a;
    endcase
  endfunction

  assign alu_f = alu_model(alu_oc, alu_a, alu_b);

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_oc(req_oc), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_f(rsp_f),
    .rsp_err(rsp_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Rotating-priority winner: first requester after the previous winner.
  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; req = '0; rsp_ready = 1'b0;
    step();
    rst_n = 1'b1;
    m_last = NREQ - 1;
  endtask

  // One full transaction starting with the DUT idle. r must be non-zero.
  // junk drives req while busy; hold = cycles rsp_ready stays low once valid.
  task automatic txn(input logic [NREQ-1:0] r, input logic [3*NREQ-1:0] oc,
                     input logic [4*NREQ-1:0] a, input logic [4*NREQ-1:0] b,
                     input int hold, input logic [NREQ-1:0] junk, output int w);
    logic [2:0] eoc;
    logic [3:0] ea, eb, ef;
    logic       eerr;
    req = r; req_oc = oc; req_a = a; req_b = b; rsp_ready = 1'b0;
    w   = pick(r, m_last);
    eoc = oc[3*w +: 3];
    ea  = a[4*w +: 4];
    eb  = b[4*w +: 4];
    eerr = (eoc == 3'b011) && (eb == 4'h0);
    ef   = eerr ? 4'hF : alu_model(eoc, ea, eb);
    step();
    g_seen = gnt; g_cyc = cyc;
    chk("gnt", gnt, 32'(1) << w);
    chk("alu_oc", alu_oc, eoc);
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("busy_exec", busy, 1);
    chk("valid_exec", rsp_valid, 0);
    m_last = w;
    req = junk; req_oc = $urandom; req_a = $urandom; req_b = $urandom;
    step();
    chk("valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, w);
    chk("rsp_f", rsp_f, ef);
    chk("rsp_err", rsp_err, eerr);
    chk("gnt_exec", gnt, 0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_id", rsp_id, w);
      chk("hold_f", rsp_f, ef);
      chk("hold_err", rsp_err, eerr);
      chk("hold_busy", busy, 1);
      chk("hold_gnt", gnt, 0);
    end
    rsp_ready = 1'b1;
    step();
    chk("valid_drop", rsp_valid, 0);
    chk("busy_drop", busy, 0);
    chk("gnt_resp", gnt, 0);
    rsp_ready = 1'b0;
    req = '0;
  endtask

  initial begin
    int w, prev;
    logic [NREQ-1:0] r;
    rst_n = 1'b0; req = '0; req_oc = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    m_last = NREQ - 1;
    step();
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_f", rsp_f, 0);
    rst_n = 1'b1;

    // Requester 2: 7 + 5 = 0xC.
    txn(4'b0100, 12'h000, 16'h0700, 16'h0500, 0, 4'b0000, w);
    chk("t1_gnt", g_seen, 4'b0100);

    // Round robin from reset with all requesters active, 3-cycle spacing.
    do_reset();
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      txn(4'b1111, $urandom, $urandom, $urandom, 0, 4'b0000, w);
      chk("rr_gnt", g_seen, 32'(1) << (n % 4));
      if (n > 0) chk("rr_spacing", g_cyc - prev, 3);
      prev = g_cyc;
    end

    // Divide by zero on requester 1, then a legal divide 9/2 = 4.
    txn(4'b0010, 12'o0030, 16'h0090, 16'h0000, 0, 4'b0000, w);
    chk("div0_gnt", g_seen, 4'b0010);
    txn(4'b0010, 12'o0030, 16'h0090, 16'h0020, 0, 4'b0000, w);
    chk("div_gnt", g_seen, 4'b0010);

    // Stalled response with competing requests held the whole time.
    txn(4'b0001, $urandom, $urandom, $urandom, 5, 4'b0011, w);
    txn(4'b0011, $urandom, $urandom, $urandom, 0, 4'b0000, w);

    // Reset while in EXEC aborts the operation.
    req = 4'b0100; req_oc = 12'hFFF; req_a = 16'hFFFF; req_b = 16'hFFFF;
    step();
    chk("pre_rst_gnt", gnt, 4'b0100);
    rst_n = 1'b0; req = '0;
    step();
    chk("abort_gnt", gnt, 0);
    chk("abort_oc", alu_oc, 0);
    chk("abort_a", alu_a, 0);
    chk("abort_b", alu_b, 0);
    chk("abort_valid", rsp_valid, 0);
    chk("abort_id", rsp_id, 0);
    chk("abort_f", rsp_f, 0);
    chk("abort_err", rsp_err, 0);
    chk("abort_busy", busy, 0);
    rst_n = 1'b1; m_last = NREQ - 1;
    step();
    chk("post_rst_valid", rsp_valid, 0);
    step();
    chk("post_rst_valid2", rsp_valid, 0);
    txn(4'b1000, $urandom, $urandom, $urandom, 0, 4'b0000, w);
    chk("post_rst_g3", g_seen, 4'b1000);
    txn(4'b1001, $urandom, $urandom, $urandom, 0, 4'b0000, w);
    chk("post_rst_g0", g_seen, 4'b0001);

    // req[2] raised only while busy: it must never win.
    txn(4'b0001, $urandom, $urandom, $urandom, 2, 4'b0100, w);
    txn(4'b1001, $urandom, $urandom, $urandom, 0, 4'b0000, w);
    chk("withdraw_not2", g_seen[2], 0);

    // Randomized traffic with idle gaps.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        step();
        chk("idle_gnt", gnt, 0);
        chk("idle_busy", busy, 0);
      end
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      txn(r, $urandom, $urandom, $urandom, $urandom_range(0, 3), NREQ'($urandom), w);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
